// File: rtl/gray_pkg.sv
// +--------------------------------------------------------------------------+
// | gray_pkg : shared Gray-code types, width constant and encoder helper      |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package gray_pkg;

   localparam int GRAY_WIDTH = 4;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } gray_tx_state_t;

   // Written for the default width; also used by the decoder bench.
   function automatic logic [GRAY_WIDTH-1:0] bin2gray(input logic [GRAY_WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/switch_debounce.sv
// +--------------------------------------------------------------------------+
// | switch_debounce : 2-flop synchronizer plus run-length debounce counter    |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module switch_debounce
   import gray_pkg::*;
#(
   parameter int WIDTH           = GRAY_WIDTH,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_i,
   output logic [WIDTH-1:0] stable_o
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   always_comb begin
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = '0;
      end else begin
         if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
         end
         // Counter saturates, so the commit fires exactly once per run.
         if (cnt_q == CNT_LAST) begin
            stable_d = cand_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         cand_q   <= '0;
         cnt_q    <= '0;
         stable_q <= '0;
      end else begin
         sync1_q  <= sw_i;
         sync2_q  <= sync1_q;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_o = stable_q;

endmodule

`default_nettype wire

// File: rtl/gray_encoder_sync.sv
// +--------------------------------------------------------------------------+
// | gray_encoder_sync : debounced switch word to Gray code, valid/ready out   |
// | Option   : GRAY_PARITY_EN adds registered gray_parity output              |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module gray_encoder_sync
   import gray_pkg::*;
#(
   parameter int WIDTH           = GRAY_WIDTH,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw,
   input  logic             gray_ready,
   output logic [WIDTH-1:0] gray_code,
   output logic [WIDTH-1:0] bin_code,
`ifdef GRAY_PARITY_EN
   output logic             gray_parity,
`endif
   output logic             gray_valid
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] enc;
   logic [WIDTH-1:0] last_bin_q, last_bin_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   gray_tx_state_t   state_q, state_d;
`ifdef GRAY_PARITY_EN
   logic             parity_q, parity_d;
`endif

   switch_debounce #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_i     (sw),
      .stable_o (stable)
   );

   generate
      if (WIDTH == GRAY_WIDTH) begin : g_pkg_enc
         assign enc = bin2gray(stable);
      end else begin : g_gen_enc
         assign enc = stable ^ (stable >> 1);
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      last_bin_d = last_bin_q;
      gray_d     = gray_q;
      bin_d      = bin_q;
`ifdef GRAY_PARITY_EN
      parity_d   = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (stable != last_bin_q) begin
               gray_d     = enc;
               bin_d      = stable;
               last_bin_d = stable;
`ifdef GRAY_PARITY_EN
               parity_d   = ^enc;
`endif
               state_d    = PEND;
            end
         end
         PEND: begin
            // Word is frozen here; newer stable values wait for IDLE.
            if (gray_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         last_bin_q <= '0;
         gray_q     <= '0;
         bin_q      <= '0;
`ifdef GRAY_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         last_bin_q <= last_bin_d;
         gray_q     <= gray_d;
         bin_q      <= bin_d;
`ifdef GRAY_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign gray_code  = gray_q;
   assign bin_code   = bin_q;
   assign gray_valid = (state_q == PEND);
`ifdef GRAY_PARITY_EN
   assign gray_parity = parity_q;
`endif

endmodule

`default_nettype wire

// File: doc/gray_encoder_sync.md
Name: gray_encoder_sync

Overview:
- Input-side counterpart of the Gray-to-binary/display path: turns raw slide-switch binary into a debounced Gray-coded word.
- Delivers the word to the downstream decoder/display chain over a valid/ready handshake, one transfer per committed change.
- Sits between the board switch pins and the Gray decoder input register; one clock domain.

Parameters:
- WIDTH, 4, bit width of the switch input and the binary/Gray outputs.
- DEBOUNCE_CYCLES, 4, consecutive equal synchronized samples required before a value is accepted; legal range >= 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- sw  in  WIDTH  raw asynchronous switch inputs (binary).
- gray_code  out  WIDTH  Gray encoding of the committed value: bin ^ (bin >> 1).
- bin_code  out  WIDTH  committed binary value matching gray_code.
- gray_valid  out  1  transfer pending; gray_code and bin_code are stable while high.
- gray_ready  in  1  downstream accepts on a cycle where gray_valid && gray_ready.

Behaviour:
- Reset (rst_n=0 at an edge): sync1, sync2, cand, stable, last_bin, cnt, gray_code, bin_code = 0; gray_valid = 0; FSM enters IDLE.
  - Reset mid-transfer drops the pending word with no handshake completion.
  - A post-reset all-zero sw produces no event.
- Synchronizer: 2-flop chain sw -> sync1 -> sync2.
- Debounce, per edge, with s = sync2:
  - If s != cand: cand <= s, cnt <= 0.
  - Else if cnt < DEBOUNCE_CYCLES: cnt <= cnt+1, saturating at DEBOUNCE_CYCLES.
  - When s == cand and cnt == DEBOUNCE_CYCLES-1: stable <= cand.
  - cnt width: $clog2(DEBOUNCE_CYCLES+1).
- FSM, 2 states:
  - IDLE: if stable != last_bin, then gray_code <= stable ^ (stable>>1), bin_code <= stable, last_bin <= stable, gray_valid <= 1; go to PEND. Otherwise stay.
  - PEND: outputs held. If gray_ready, then gray_valid <= 0; go to IDLE.
- Latency: sw change first captured by sync1 at edge E -> gray_valid high after edge E+DEBOUNCE_CYCLES+3, i.e. D+4 edges counting the capture edge.
- Glitch shorter than DEBOUNCE_CYCLES samples: no event; stable unchanged.
- Changes while in PEND are not lost and do not overwrite the pending word.
  - stable keeps tracking sw.
  - After acceptance, IDLE compares the latest stable to last_bin. At most one new transfer, carrying the final value; intermediate values are skipped.
- gray_ready high in IDLE: ignored.
- Back-to-back transfers: minimum one IDLE cycle between a transfer's acceptance and the next gray_valid.
- A change that returns to last_bin before the next commit: no event.
- Wrap-around 1111 -> 0000: normal event, gray 1000 -> 0000.

Optional Feature:
- Macro GRAY_PARITY_EN.
- Defined: extra output port gray_parity (1 bit) = ^gray_code, registered together with gray_code; 0 at reset; held in PEND.
- Undefined: port absent; no parity logic.

Decomposition:
- Package gray_pkg:
  - typedef enum logic {IDLE, PEND} gray_tx_state_t.
  - function bin2gray(logic [WIDTH-1:0]), written for the default width 4 and shared with the decoder bench.
  - Constant GRAY_WIDTH = 4.
- Sub-module switch_debounce: sync chain plus counter, output stable. Instantiated once; the FSM and encoding stay in the top.

Test Plan:
- Reset with sw=0000, hold 20 cycles -> gray_valid stays 0; gray_code=0000, bin_code=0000.
- sw 0000->0101, gray_ready=1 -> gray_valid for exactly 1 cycle, D+4 edges after capture; gray_code=0111, bin_code=0101.
- gray_ready=0, sw=0110; then sw=1111 during PEND; release ready after 10 cycles -> first transfer gray 0101 held stable until accepted; then exactly one transfer with gray 1000, bin 1111.
- 2-cycle glitch 0000->0011->0000 with D=4 -> no gray_valid.
- Pulse rst_n=0 for one edge while in PEND -> next cycle gray_valid=0, outputs 0000; a subsequent sw=0001 produces gray 0001.
- Sweep sw 0..15 sequentially with ready=1 -> 15 transfers (0000 is not a change); each gray_code equals bin^(bin>>1). With GRAY_PARITY_EN, gray_parity = ^gray_code; for bin 1001, gray 1101, parity 1.
